spm_router_seq: RTL
===================

SPM_ROUTER_SEQ -- requirements
Module: spm_router_seq

Interface
REQ-001 Parameter NUM_BG, default 4, number of bank groups served.
REQ-002 Parameter A_W, default 8, bank-group address width.
REQ-003 Parameter D_W, default 32, data width.
REQ-004 Parameter BUF_DEPTH, default 16, configuration-buffer entries (power of two, >=2).
REQ-005 Parameter INST_W, fixed 6*NUM_BG; per-BG field b at [6b+5:6b] = {flush, fifo_sel[1:0], en, sel, mode}.
REQ-006 Port list: clk input 1, the single clock. One clock; reset is asynchronous and active-low.
REQ-007 rst input 1: asynchronous, active-low reset.
REQ-008 init input 1: write inst into the configuration buffer.
REQ-009 inst input INST_W: configuration word.
REQ-010 run input 1: advance to the next configuration word.
REQ-011 cfg_clear input 1: synchronous flush of the buffer pointers.
REQ-012 ex_wen, ex_ren inputs NUM_BG: external-port strobes, one per BG.
REQ-013 ex_addr input NUM_BG*A_W, ex_data input NUM_BG*D_W: external-port address and data.
REQ-014 sw_wen, sw_ren inputs NUM_BG: switch-port strobes.
REQ-015 sw_addr input NUM_BG*A_W, sw_data input NUM_BG*D_W: switch-port address and data.
REQ-016 bg_en, bg_mode, bg_flush outputs NUM_BG; bg_fifo_sel output 2*NUM_BG: registered controls.
REQ-017 bg_wen, bg_ren outputs NUM_BG; bg_addr output NUM_BG*A_W; bg_data output NUM_BG*D_W: registered bank-group ports.
REQ-018 cfg_count output $clog2(BUF_DEPTH)+1; cfg_full output 1; cfg_ovf output 1 (sticky); run_wrap output 1 (pulse).
REQ-019 ex_conflict output NUM_BG: sticky per-BG conflict flags.

Function
REQ-020 init with cfg_full=0 SHALL write buf[wr_ptr]<=inst, and SHALL increment wr_ptr and cfg_count.
REQ-021 cfg_full SHALL equal (cfg_count==BUF_DEPTH); init while full SHALL discard inst and set cfg_ovf.
REQ-022 run with cfg_count>0 SHALL load inst_r<=buf[rd_ptr]; rd_ptr SHALL advance, wrapping to 0 after cfg_count-1, and run_wrap SHALL pulse for exactly that load cycle.
REQ-023 run with cfg_count==0 SHALL leave inst_r, rd_ptr and run_wrap unchanged (run_wrap=0).
REQ-024 Priority SHALL be: cfg_clear > init > run; a lower-priority request in the same cycle SHALL be ignored.
REQ-025 cfg_clear SHALL zero wr_ptr, rd_ptr, cfg_count, inst_r and cfg_ovf, and SHALL leave buffer contents unchanged.
REQ-026 For each BG b, sel=1 SHALL select the sw_* inputs, and sel=0 SHALL select the ex_* inputs, for addr, data, wen and ren.
REQ-027 bg_wen[b] and bg_ren[b] SHALL be forced to 0 when en=0 in inst_r.
REQ-028 All bg_* outputs SHALL register the current-cycle inst_r fields and muxed inputs, giving latency of exactly 1 cycle from input to output.
REQ-029 A control change from run SHALL appear on bg_* 2 cycles after the run edge (inst_r load, then the output register).

Reset
REQ-030 rst low SHALL asynchronously clear inst_r, the pointers, cfg_count, cfg_ovf, run_wrap, ex_conflict and all bg_* outputs to 0.
REQ-031 Buffer contents SHALL NOT be reset.
REQ-032 An init or run request coincident with rst low SHALL be lost.

Configuration
REQ-033 Macro SPM_CONFLICT_DET_EN defined: ex_conflict[b] SHALL set when inst_r has sel=1, en=1 and (ex_wen[b]|ex_ren[b]), and SHALL clear only on rst or cfg_clear.
REQ-034 Macro SPM_CONFLICT_DET_EN undefined: ex_conflict SHALL be constant 0 and no detection logic SHALL be built.

Structure
REQ-035 Package spm_pkg SHALL hold the per-BG field offsets (MODE=0, SEL=1, EN=2, FSEL=3..4, FLUSH=5), the field width 6, and the default parameter constants.
REQ-036 Sub-module spm_cfg_buffer SHALL contain the storage, pointers, count, full/ovf logic and wrap logic.
REQ-037 spm_router_seq SHALL contain the per-BG mux and output registers in a generate loop.

Verification
REQ-038 Load 3 words (W0..W2) via init, then apply 4 run pulses -> inst_r sequence W0,W1,W2,W0; run_wrap high on the W2 load only.
REQ-039 Apply 17 consecutive init cycles at BUF_DEPTH=16 -> cfg_count=16, cfg_full=1, cfg_ovf=1, buf[0] unchanged by the 17th word.
REQ-040 Assert init and run in the same cycle with count=2 -> count=3, rd_ptr unchanged; then assert cfg_clear with init -> count=0, buffer intact.
REQ-041 Set BG1 sel=1, en=1, sw_addr=0x5A, sw_wen=1, ex_wen=1 -> next cycle bg_addr[1]=0x5A, bg_wen[1]=1, ex_conflict[1]=1 with the macro, 0 without it.
REQ-042 Set BG2 en=0 with ex_ren=1 -> bg_ren[2]=0 while bg_addr[2] still follows ex_addr.
REQ-043 Drop rst low mid-run after 2 loads -> all outputs 0 immediately; after release, run with the count at 0 -> no change.

Source files
------------

// File: rtl/spm_router_seq_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg -- shared constants and types for the SPM router sequencer.
//
// Holds the layout of one bank-group field inside a configuration word
// ({flush, fifo_sel[1:0], en, sel, mode}, 6 bits per BG), the default
// parameter values, and a helper that unpacks one field into a struct.
// -----------------------------------------------------------------------------
package spm_pkg;

  // Default parameter values.
  localparam int DEF_NUM_BG    = 4;
  localparam int DEF_A_W       = 8;
  localparam int DEF_D_W       = 32;
  localparam int DEF_BUF_DEPTH = 16;

  // Per-BG field layout inside the configuration word.
  localparam int FLD_W      = 6;
  localparam int FLD_MODE   = 0;
  localparam int FLD_SEL    = 1;
  localparam int FLD_EN     = 2;
  localparam int FLD_FSEL   = 3;
  localparam int FLD_FSEL_W = 2;
  localparam int FLD_FLUSH  = 5;

  typedef struct packed {
    logic                  flush;
    logic [FLD_FSEL_W-1:0] fifo_sel;
    logic                  en;
    logic                  sel;
    logic                  mode;
  } bg_ctrl_t;

  // Unpack one BG field by named offsets so the layout lives in one place.
  function automatic bg_ctrl_t unpack_ctrl(input logic [FLD_W-1:0] f);
    bg_ctrl_t c;
    c.mode     = f[FLD_MODE];
    c.sel      = f[FLD_SEL];
    c.en       = f[FLD_EN];
    c.fifo_sel = f[FLD_FSEL +: FLD_FSEL_W];
    c.flush    = f[FLD_FLUSH];
    return c;
  endfunction

endpackage

// File: rtl/spm_router_seq_if.sv
// -----------------------------------------------------------------------------
// spm_router_seq_if -- bus bundle between the SPM router sequencer and its
// environment.
//
// Handshake semantics: there is no valid/ready back-pressure on this block.
// Every strobe (init, run, cfg_clear, ex_wen/ex_ren, sw_wen/sw_ren) is a
// single-cycle qualifier sampled on the rising clock edge; the block always
// accepts it (init while full is accepted and dropped, raising cfg_ovf).
// All outputs are registered and change only on the clock edge or reset.
//
// Signals:
//   init, inst, run, cfg_clear      configuration buffer control
//   ex_* / sw_*                     external and switch ports, one lane per BG
//   bg_*                            registered bank-group controls and ports
//   cfg_count/full/ovf, run_wrap    buffer status
//   ex_conflict                     sticky per-BG conflict flags
//   dbg_rd_ptr, dbg_wr_ptr, dbg_inst  internal pointer / active word view
// Modports: master = environment side, slave = router side.
// -----------------------------------------------------------------------------
interface spm_router_seq_if #(
  parameter int NUM_BG    = spm_pkg::DEF_NUM_BG,
  parameter int A_W       = spm_pkg::DEF_A_W,
  parameter int D_W       = spm_pkg::DEF_D_W,
  parameter int BUF_DEPTH = spm_pkg::DEF_BUF_DEPTH
);
  localparam int INST_W = spm_pkg::FLD_W * NUM_BG;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Environment -> router.
  logic                  init;
  logic [INST_W-1:0]     inst;
  logic                  run;
  logic                  cfg_clear;
  logic [NUM_BG-1:0]     ex_wen;
  logic [NUM_BG-1:0]     ex_ren;
  logic [NUM_BG*A_W-1:0] ex_addr;
  logic [NUM_BG*D_W-1:0] ex_data;
  logic [NUM_BG-1:0]     sw_wen;
  logic [NUM_BG-1:0]     sw_ren;
  logic [NUM_BG*A_W-1:0] sw_addr;
  logic [NUM_BG*D_W-1:0] sw_data;

  // Router -> environment (nets: driven per lane from a generate loop).
  wire [NUM_BG-1:0]      bg_en;
  wire [NUM_BG-1:0]      bg_mode;
  wire [NUM_BG-1:0]      bg_flush;
  wire [2*NUM_BG-1:0]    bg_fifo_sel;
  wire [NUM_BG-1:0]      bg_wen;
  wire [NUM_BG-1:0]      bg_ren;
  wire [NUM_BG*A_W-1:0]  bg_addr;
  wire [NUM_BG*D_W-1:0]  bg_data;
  wire [CNT_W-1:0]       cfg_count;
  wire                   cfg_full;
  wire                   cfg_ovf;
  wire                   run_wrap;
  wire [NUM_BG-1:0]      ex_conflict;
  wire [PTR_W-1:0]       dbg_rd_ptr;
  wire [PTR_W-1:0]       dbg_wr_ptr;
  wire [INST_W-1:0]      dbg_inst;

  modport master (
    output init, inst, run, cfg_clear,
    output ex_wen, ex_ren, ex_addr, ex_data,
    output sw_wen, sw_ren, sw_addr, sw_data,
    input  bg_en, bg_mode, bg_flush, bg_fifo_sel,
    input  bg_wen, bg_ren, bg_addr, bg_data,
    input  cfg_count, cfg_full, cfg_ovf, run_wrap, ex_conflict,
    input  dbg_rd_ptr, dbg_wr_ptr, dbg_inst
  );

  modport slave (
    input  init, inst, run, cfg_clear,
    input  ex_wen, ex_ren, ex_addr, ex_data,
    input  sw_wen, sw_ren, sw_addr, sw_data,
    output bg_en, bg_mode, bg_flush, bg_fifo_sel,
    output bg_wen, bg_ren, bg_addr, bg_data,
    output cfg_count, cfg_full, cfg_ovf, run_wrap, ex_conflict,
    output dbg_rd_ptr, dbg_wr_ptr, dbg_inst
  );

endinterface

// File: rtl/spm_router_seq_cfg_buffer.sv
// -----------------------------------------------------------------------------
// spm_cfg_buffer -- configuration word buffer with cyclic playback.
//
// init appends a word (dropped with cfg_ovf set when full); run loads the
// word at rd_ptr into inst_r and advances rd_ptr, wrapping to 0 after the
// last written entry, with run_wrap high while the wrapped word is loaded.
// Priority: clear > init > run. Storage is never reset or cleared.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   init_i, inst_i       append request and word
//   run_i                advance request
//   clear_i              synchronous pointer/count/inst_r/ovf flush
//   inst_r_o             active configuration word
//   rd_ptr_o, wr_ptr_o   pointers (debug view)
//   count_o, full_o      entries written, buffer full
//   ovf_o                sticky overflow flag
//   run_wrap_o           pulse on the load that wraps rd_ptr
// -----------------------------------------------------------------------------
module spm_cfg_buffer #(
  parameter int INST_W    = spm_pkg::FLD_W * spm_pkg::DEF_NUM_BG,
  parameter int BUF_DEPTH = spm_pkg::DEF_BUF_DEPTH,
  localparam int PTR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              run_i,
  input  logic              clear_i,
  output logic [INST_W-1:0] inst_r_o,
  output logic [PTR_W-1:0]  rd_ptr_o,
  output logic [PTR_W-1:0]  wr_ptr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              run_wrap_o
);

  logic [INST_W-1:0] mem_q [BUF_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [INST_W-1:0] inst_r_q,   inst_r_d;
  logic              ovf_q,      ovf_d;
  logic              run_wrap_q, run_wrap_d;
  logic              mem_we;
  logic              full;

  assign full = (count_q == CNT_W'(BUF_DEPTH));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_r_d   = inst_r_q;
    ovf_d      = ovf_q;
    run_wrap_d = 1'b0;
    mem_we     = 1'b0;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      inst_r_d = '0;
      ovf_d    = 1'b0;
    end else if (init_i) begin
      if (!full) begin
        // Storage has no reset, so a write coincident with reset is
        // suppressed here to keep that request lost.
        mem_we   = rst_ni;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (run_i && (count_q != '0)) begin
      inst_r_d = mem_q[rd_ptr_q];
      // Playback covers only the entries written so far, not the full depth.
      if ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1))) begin
        rd_ptr_d   = '0;
        run_wrap_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inst_r_q   <= '0;
      ovf_q      <= 1'b0;
      run_wrap_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_r_q   <= inst_r_d;
      ovf_q      <= ovf_d;
      run_wrap_q <= run_wrap_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= inst_i;
  end

  assign inst_r_o   = inst_r_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign wr_ptr_o   = wr_ptr_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign ovf_o      = ovf_q;
  assign run_wrap_o = run_wrap_q;

endmodule

// File: rtl/spm_router_seq.sv
// -----------------------------------------------------------------------------
// spm_router_seq -- sequenced bank-group router.
//
// A configuration buffer (spm_cfg_buffer) supplies the active word inst_r.
// For each bank group the word selects switch (sel=1) or external (sel=0)
// address/data/strobes; strobes are masked when en=0. Every bg_* output is
// a register of the current inst_r fields and muxed inputs (1-cycle latency).
//
// Ports:
//   clk   single clock
//   rst   asynchronous active-low reset
//   bus   spm_router_seq_if.slave: config, ex/sw ports, bg outputs, status
//
// Build option: define SPM_CONFLICT_DET_EN to build sticky per-BG conflict
// flags (external strobe while the BG is routed to the switch port and
// enabled). Without it ex_conflict is tied to 0.
// -----------------------------------------------------------------------------
module spm_router_seq #(
  parameter int NUM_BG    = spm_pkg::DEF_NUM_BG,
  parameter int A_W       = spm_pkg::DEF_A_W,
  parameter int D_W       = spm_pkg::DEF_D_W,
  parameter int BUF_DEPTH = spm_pkg::DEF_BUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  spm_router_seq_if.slave bus
);
  import spm_pkg::*;

  localparam int INST_W = FLD_W * NUM_BG;
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [INST_W-1:0] inst_r;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              ovf;
  logic              run_wrap;

  spm_cfg_buffer #(
    .INST_W    (INST_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_cfg_buffer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .init_i     (bus.init),
    .inst_i     (bus.inst),
    .run_i      (bus.run),
    .clear_i    (bus.cfg_clear),
    .inst_r_o   (inst_r),
    .rd_ptr_o   (rd_ptr),
    .wr_ptr_o   (wr_ptr),
    .count_o    (count),
    .full_o     (full),
    .ovf_o      (ovf),
    .run_wrap_o (run_wrap)
  );

  assign bus.cfg_count  = count;
  assign bus.cfg_full   = full;
  assign bus.cfg_ovf    = ovf;
  assign bus.run_wrap   = run_wrap;
  assign bus.dbg_rd_ptr = rd_ptr;
  assign bus.dbg_wr_ptr = wr_ptr;
  assign bus.dbg_inst   = inst_r;

  for (genvar b = 0; b < NUM_BG; b++) begin : g_bg
    bg_ctrl_t        ctrl;
    logic            wen_mux;
    logic            ren_mux;
    logic [A_W-1:0]  addr_mux;
    logic [D_W-1:0]  data_mux;

    logic            en_q;
    logic            mode_q;
    logic            flush_q;
    logic [1:0]      fsel_q;
    logic            wen_q;
    logic            ren_q;
    logic [A_W-1:0]  addr_q;
    logic [D_W-1:0]  data_q;

    assign ctrl     = unpack_ctrl(inst_r[FLD_W*b +: FLD_W]);
    assign wen_mux  = ctrl.sel ? bus.sw_wen[b] : bus.ex_wen[b];
    assign ren_mux  = ctrl.sel ? bus.sw_ren[b] : bus.ex_ren[b];
    assign addr_mux = ctrl.sel ? bus.sw_addr[A_W*b +: A_W] : bus.ex_addr[A_W*b +: A_W];
    assign data_mux = ctrl.sel ? bus.sw_data[D_W*b +: D_W] : bus.ex_data[D_W*b +: D_W];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_q    <= 1'b0;
        mode_q  <= 1'b0;
        flush_q <= 1'b0;
        fsel_q  <= '0;
        wen_q   <= 1'b0;
        ren_q   <= 1'b0;
        addr_q  <= '0;
        data_q  <= '0;
      end else begin
        en_q    <= ctrl.en;
        mode_q  <= ctrl.mode;
        flush_q <= ctrl.flush;
        fsel_q  <= ctrl.fifo_sel;
        // Address/data pass through even when disabled; only strobes are masked.
        wen_q   <= ctrl.en & wen_mux;
        ren_q   <= ctrl.en & ren_mux;
        addr_q  <= addr_mux;
        data_q  <= data_mux;
      end
    end

    assign bus.bg_en[b]              = en_q;
    assign bus.bg_mode[b]            = mode_q;
    assign bus.bg_flush[b]           = flush_q;
    assign bus.bg_fifo_sel[2*b +: 2] = fsel_q;
    assign bus.bg_wen[b]             = wen_q;
    assign bus.bg_ren[b]             = ren_q;
    assign bus.bg_addr[A_W*b +: A_W] = addr_q;
    assign bus.bg_data[D_W*b +: D_W] = data_q;

`ifdef SPM_CONFLICT_DET_EN
    logic conflict_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        conflict_q <= 1'b0;
      end else if (bus.cfg_clear) begin
        conflict_q <= 1'b0;
      end else if (ctrl.sel && ctrl.en && (bus.ex_wen[b] || bus.ex_ren[b])) begin
        conflict_q <= 1'b1;
      end
    end
    assign bus.ex_conflict[b] = conflict_q;
`else
    assign bus.ex_conflict[b] = 1'b0;
`endif
  end

endmodule
